// File: rtl/sh_mem_responder_if.sv
// Bus bundle between the core's instruction/data memory ports and the memory responder.
// The master side drives requests and the slave side returns ready/valid responses.
interface sh_mem_responder_if;
    // Instruction fetch port
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ready;
    logic        i_valid;
    logic [15:0] i_rdata;
    logic        i_err;

    // Data load/store port
    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        d_err;

    modport master (
        output i_req, i_addr,
        output d_req, d_we, d_size, d_addr, d_wdata,
        input  i_ready, i_valid, i_rdata, i_err,
        input  d_ready, d_valid, d_rdata, d_err
    );

    modport slave (
        input  i_req, i_addr,
        input  d_req, d_we, d_size, d_addr, d_wdata,
        output i_ready, i_valid, i_rdata, i_err,
        output d_ready, d_valid, d_rdata, d_err
    );
endinterface

// File: rtl/sh_mem_responder.sv
// Shared big-endian 32-bit memory serving a 16-bit fetch port and a byte/word/long data port,
// each with its own accept/wait/respond sequencer and a fixed number of wait states.
module sh_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                clk,
    input  logic                n_reset,
    sh_mem_responder_if.slave   bus,
    output logic [1:0]          i_state_dbg,
    output logic [1:0]          d_state_dbg
);

    localparam int unsigned AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Handshake: a request is taken at a rising edge where req and ready are both high;
    // ready depends on sequencer state only, valid is high for exactly one cycle (RESP),
    // and rdata/err are meaningful only while valid is high.

    logic [31:0] mem_q [DEPTH_WORDS];

    // ------------------------------------------------------------------
    // Fetch port decode
    // ------------------------------------------------------------------
    state_e      i_state_q, i_state_d;
    logic [3:0]  i_cnt_q, i_cnt_d;
    logic [15:0] i_hold_q, i_hold_d;
    logic        i_herr_q, i_herr_d;
    logic [15:0] i_rdata_q, i_rdata_d;
    logic        i_err_q, i_err_d;

    logic          i_ready;
    logic          i_accept;
    logic [AW-1:0] i_idx;
    logic          i_in_range;
    logic          i_fault;
    logic [31:0]   i_word;
    logic [15:0]   i_fresh;

    assign i_ready    = (i_state_q != ST_WAIT);
    assign i_accept   = bus.i_req && i_ready;
    assign i_idx      = bus.i_addr[AW+1:2];
    assign i_in_range = ({2'b00, bus.i_addr[31:2]} < DEPTH_WORDS);
    assign i_fault    = bus.i_addr[0] || !i_in_range;
    assign i_word     = mem_q[i_idx];

    always_comb begin
        i_fresh = 16'h0000;
        if (!i_fault) begin
            i_fresh = bus.i_addr[1] ? i_word[15:0] : i_word[31:16];
        end
    end

    // ------------------------------------------------------------------
    // Fetch sequencer
    // ------------------------------------------------------------------
    always_comb begin
        i_state_d = i_state_q;
        i_cnt_d   = i_cnt_q;
        i_hold_d  = i_hold_q;
        i_herr_d  = i_herr_q;
        i_rdata_d = i_rdata_q;
        i_err_d   = i_err_q;
        case (i_state_q)
            ST_WAIT: begin
                if (i_cnt_q == 4'd0) begin
                    i_state_d = ST_RESP;
                    i_rdata_d = i_hold_q;
                    i_err_d   = i_herr_q;
                end else begin
                    i_cnt_d = i_cnt_q - 4'd1;
                end
            end
            default: begin
                if (i_accept) begin
                    if (WAIT_STATES == 0) begin
                        i_state_d = ST_RESP;
                        i_rdata_d = i_fresh;
                        i_err_d   = i_fault;
                    end else begin
                        i_state_d = ST_WAIT;
                        i_cnt_d   = WS_LOAD;
                        i_hold_d  = i_fresh;
                        i_herr_d  = i_fault;
                    end
                end else begin
                    i_state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            i_state_q <= ST_IDLE;
            i_cnt_q   <= 4'd0;
            i_hold_q  <= 16'h0000;
            i_herr_q  <= 1'b0;
            i_rdata_q <= 16'h0000;
            i_err_q   <= 1'b0;
        end else begin
            i_state_q <= i_state_d;
            i_cnt_q   <= i_cnt_d;
            i_hold_q  <= i_hold_d;
            i_herr_q  <= i_herr_d;
            i_rdata_q <= i_rdata_d;
            i_err_q   <= i_err_d;
        end
    end

    assign bus.i_ready = i_ready;
    assign bus.i_valid = (i_state_q == ST_RESP);
    assign bus.i_rdata = i_rdata_q;
    assign bus.i_err   = i_err_q;
    assign i_state_dbg = i_state_q;

    // ------------------------------------------------------------------
    // Data port decode
    // ------------------------------------------------------------------
    state_e      d_state_q, d_state_d;
    logic [3:0]  d_cnt_q, d_cnt_d;
    logic [31:0] d_hold_q, d_hold_d;
    logic        d_herr_q, d_herr_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        d_err_q, d_err_d;

    logic          d_ready;
    logic          d_accept;
    logic [AW-1:0] d_idx;
    logic          d_in_range;
    logic [31:0]   d_word;
    logic          d_fault;
    logic [3:0]    d_be;
    logic [31:0]   d_wr_word;
    logic [31:0]   d_fresh;
    logic          d_wr_en;

    assign d_ready    = (d_state_q != ST_WAIT);
    assign d_accept   = bus.d_req && d_ready;
    assign d_idx      = bus.d_addr[AW+1:2];
    assign d_in_range = ({2'b00, bus.d_addr[31:2]} < DEPTH_WORDS);
    assign d_word     = mem_q[d_idx];

    // Lane select: byte offset 0 is the most significant byte of the stored word.
    always_comb begin
        d_fault   = !d_in_range;
        d_be      = 4'b0000;
        d_wr_word = 32'h0000_0000;
        d_fresh   = 32'h0000_0000;
        case (bus.d_size)
            2'b00: begin
                d_wr_word = {4{bus.d_wdata[7:0]}};
                case (bus.d_addr[1:0])
                    2'd0: begin d_be = 4'b1000; d_fresh = {24'h0, d_word[31:24]}; end
                    2'd1: begin d_be = 4'b0100; d_fresh = {24'h0, d_word[23:16]}; end
                    2'd2: begin d_be = 4'b0010; d_fresh = {24'h0, d_word[15:8]};  end
                    default: begin d_be = 4'b0001; d_fresh = {24'h0, d_word[7:0]}; end
                endcase
            end
            2'b01: begin
                d_wr_word = {2{bus.d_wdata[15:0]}};
                if (bus.d_addr[0]) begin
                    d_fault = 1'b1;
                end
                if (bus.d_addr[1]) begin
                    d_be    = 4'b0011;
                    d_fresh = {16'h0, d_word[15:0]};
                end else begin
                    d_be    = 4'b1100;
                    d_fresh = {16'h0, d_word[31:16]};
                end
            end
            2'b10: begin
                d_wr_word = bus.d_wdata;
                d_be      = 4'b1111;
                d_fresh   = d_word;
                if (bus.d_addr[1:0] != 2'b00) begin
                    d_fault = 1'b1;
                end
            end
            default: begin
                d_fault = 1'b1;
            end
        endcase
        // Rejected accesses and stores return zero data; rejected stores touch nothing.
        if (d_fault || bus.d_we) begin
            d_fresh = 32'h0000_0000;
        end
        if (d_fault) begin
            d_be = 4'b0000;
        end
    end

    assign d_wr_en = n_reset && d_accept && bus.d_we && !d_fault;

    // The array has no reset; reads above sample the pre-write contents at the same edge.
    always_ff @(posedge clk) begin
        if (d_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (d_be[b]) begin
                    mem_q[d_idx][8*b +: 8] <= d_wr_word[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Data sequencer
    // ------------------------------------------------------------------
    always_comb begin
        d_state_d = d_state_q;
        d_cnt_d   = d_cnt_q;
        d_hold_d  = d_hold_q;
        d_herr_d  = d_herr_q;
        d_rdata_d = d_rdata_q;
        d_err_d   = d_err_q;
        case (d_state_q)
            ST_WAIT: begin
                if (d_cnt_q == 4'd0) begin
                    d_state_d = ST_RESP;
                    d_rdata_d = d_hold_q;
                    d_err_d   = d_herr_q;
                end else begin
                    d_cnt_d = d_cnt_q - 4'd1;
                end
            end
            default: begin
                if (d_accept) begin
                    if (WAIT_STATES == 0) begin
                        d_state_d = ST_RESP;
                        d_rdata_d = d_fresh;
                        d_err_d   = d_fault;
                    end else begin
                        d_state_d = ST_WAIT;
                        d_cnt_d   = WS_LOAD;
                        d_hold_d  = d_fresh;
                        d_herr_d  = d_fault;
                    end
                end else begin
                    d_state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            d_state_q <= ST_IDLE;
            d_cnt_q   <= 4'd0;
            d_hold_q  <= 32'h0000_0000;
            d_herr_q  <= 1'b0;
            d_rdata_q <= 32'h0000_0000;
            d_err_q   <= 1'b0;
        end else begin
            d_state_q <= d_state_d;
            d_cnt_q   <= d_cnt_d;
            d_hold_q  <= d_hold_d;
            d_herr_q  <= d_herr_d;
            d_rdata_q <= d_rdata_d;
            d_err_q   <= d_err_d;
        end
    end

    assign bus.d_ready = d_ready;
    assign bus.d_valid = (d_state_q == ST_RESP);
    assign bus.d_rdata = d_rdata_q;
    assign bus.d_err   = d_err_q;
    assign d_state_dbg = d_state_q;

endmodule

// File: tb/tb_sh_mem_responder.sv
// Scoreboard bench for sh_mem_responder: one instance with no wait states, one with three.
// Expected responses are queued at acceptance and compared when valid appears.
module tb_sh_mem_responder;

  localparam int DEPTH = 4096;

  // Scoreboard entry: {check_data, err, data}
  localparam int W = 34;

  logic clk = 1'b0;
  logic n_reset;

  always #5 clk = ~clk;

  sh_mem_responder_if bus0();
  sh_mem_responder_if bus3();

  logic [1:0] i_st0, d_st0, i_st3, d_st3;

  sh_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut0 (
    .clk        (clk),
    .n_reset    (n_reset),
    .bus        (bus0),
    .i_state_dbg(i_st0),
    .d_state_dbg(d_st0)
  );

  sh_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) dut3 (
    .clk        (clk),
    .n_reset    (n_reset),
    .bus        (bus3),
    .i_state_dbg(i_st3),
    .d_state_dbg(d_st3)
  );

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_i0_q[$];
  logic [W-1:0] exp_d0_q[$];
  logic [W-1:0] exp_d3_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ld_ok(input logic [31:0] d);
    return {2'b10, d};
  endfunction

  function automatic logic [W-1:0] ld_err();
    return {2'b11, 32'h0};
  endfunction

  function automatic logic [W-1:0] st_ok();
    return {2'b00, 32'h0};
  endfunction

  function automatic logic [W-1:0] st_err();
    return {2'b01, 32'h0};
  endfunction

  // Reference extraction: byte offset 0 is the top byte of the stored word.
  function automatic logic [31:0] ref_byte(input logic [31:0] w, input logic [1:0] off);
    return (w >> ((3 - int'(off)) * 8)) & 32'h0000_00FF;
  endfunction

  function automatic logic [31:0] ref_half(input logic [31:0] w, input logic a1);
    return (w >> (a1 ? 0 : 16)) & 32'h0000_FFFF;
  endfunction

  // ---------------- response monitors ----------------
  always @(negedge clk) begin : mon_d0
    logic [W-1:0] e;
    if (n_reset && bus0.d_valid) begin
      if (exp_d0_q.size() == 0) begin
        check("d0_unexpected_valid", 64'(bus0.d_valid), 64'd0);
      end else begin
        e = exp_d0_q.pop_front();
        check("d0_err", 64'(bus0.d_err), 64'(e[32]));
        if (e[33]) check("d0_rdata", 64'(bus0.d_rdata), 64'(e[31:0]));
      end
    end
  end

  always @(negedge clk) begin : mon_i0
    logic [W-1:0] e;
    if (n_reset && bus0.i_valid) begin
      if (exp_i0_q.size() == 0) begin
        check("i0_unexpected_valid", 64'(bus0.i_valid), 64'd0);
      end else begin
        e = exp_i0_q.pop_front();
        check("i0_err", 64'(bus0.i_err), 64'(e[32]));
        if (e[33]) check("i0_rdata", 64'(bus0.i_rdata), 64'(e[31:0]));
      end
    end
  end

  always @(negedge clk) begin : mon_d3
    logic [W-1:0] e;
    if (n_reset && bus3.d_valid) begin
      if (exp_d3_q.size() == 0) begin
        check("d3_unexpected_valid", 64'(bus3.d_valid), 64'd0);
      end else begin
        e = exp_d3_q.pop_front();
        check("d3_err", 64'(bus3.d_err), 64'(e[32]));
        if (e[33]) check("d3_rdata", 64'(bus3.d_rdata), 64'(e[31:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic d0_op(input logic we, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input logic [W-1:0] exp);
    @(negedge clk);
    bus0.d_req = 1'b1; bus0.d_we = we; bus0.d_size = sz; bus0.d_addr = a; bus0.d_wdata = wd;
    for (int k = 0; k < 50 && !bus0.d_ready; k++) @(negedge clk);
    if (!bus0.d_ready) check("d0_ready_timeout", 64'(bus0.d_ready), 64'd1);
    exp_d0_q.push_back(exp);
    @(posedge clk);
  endtask

  task automatic i0_op(input logic [31:0] a, input logic [W-1:0] exp);
    @(negedge clk);
    bus0.i_req = 1'b1; bus0.i_addr = a;
    for (int k = 0; k < 50 && !bus0.i_ready; k++) @(negedge clk);
    if (!bus0.i_ready) check("i0_ready_timeout", 64'(bus0.i_ready), 64'd1);
    exp_i0_q.push_back(exp);
    @(posedge clk);
  endtask

  task automatic d3_op(input logic we, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input logic [W-1:0] exp);
    @(negedge clk);
    bus3.d_req = 1'b1; bus3.d_we = we; bus3.d_size = sz; bus3.d_addr = a; bus3.d_wdata = wd;
    for (int k = 0; k < 50 && !bus3.d_ready; k++) @(negedge clk);
    if (!bus3.d_ready) check("d3_ready_timeout", 64'(bus3.d_ready), 64'd1);
    exp_d3_q.push_back(exp);
    @(posedge clk);
  endtask

  task automatic idle_all();
    @(negedge clk);
    bus0.d_req = 1'b0;
    bus0.i_req = 1'b0;
    bus3.d_req = 1'b0;
    bus3.i_req = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && (exp_i0_q.size() + exp_d0_q.size() + exp_d3_q.size()) != 0; k++) begin
      @(negedge clk); #1;
    end
    check("drain_pending", 64'(exp_i0_q.size() + exp_d0_q.size() + exp_d3_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_d0_ready"}, 64'(bus0.d_ready), 64'd1);
    check({tag, "_i0_ready"}, 64'(bus0.i_ready), 64'd1);
    check({tag, "_d0_valid"}, 64'(bus0.d_valid), 64'd0);
    check({tag, "_i0_valid"}, 64'(bus0.i_valid), 64'd0);
    check({tag, "_d0_err"},   64'(bus0.d_err),   64'd0);
    check({tag, "_i0_err"},   64'(bus0.i_err),   64'd0);
    check({tag, "_d0_rdata"}, 64'(bus0.d_rdata), 64'd0);
    check({tag, "_i0_rdata"}, 64'(bus0.i_rdata), 64'd0);
    check({tag, "_d3_ready"}, 64'(bus3.d_ready), 64'd1);
    check({tag, "_d3_valid"}, 64'(bus3.d_valid), 64'd0);
    check({tag, "_d3_err"},   64'(bus3.d_err),   64'd0);
    check({tag, "_d3_rdata"}, 64'(bus3.d_rdata), 64'd0);
    check({tag, "_d3_state"}, 64'(d_st3), 64'd0);
    check({tag, "_i0_state"}, 64'(i_st0), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  logic [31:0] words [4];

  initial begin
    n_reset = 1'b0;
    bus0.i_req = 1'b0; bus0.i_addr = '0;
    bus0.d_req = 1'b0; bus0.d_we = 1'b0; bus0.d_size = 2'b00; bus0.d_addr = '0; bus0.d_wdata = '0;
    bus3.i_req = 1'b0; bus3.i_addr = '0;
    bus3.d_req = 1'b0; bus3.d_we = 1'b0; bus3.d_size = 2'b00; bus3.d_addr = '0; bus3.d_wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    n_reset = 1'b1;

    // Long store then sub-word loads and a fetch of the same word
    d0_op(1'b1, 2'b10, 32'h100, 32'hDEADBEEF, st_ok());
    d0_op(1'b0, 2'b00, 32'h101, 32'h0, ld_ok(32'h0000_00AD));
    d0_op(1'b0, 2'b01, 32'h102, 32'h0, ld_ok(32'h0000_BEEF));
    d0_op(1'b0, 2'b10, 32'h100, 32'h0, ld_ok(32'hDEAD_BEEF));
    idle_all();
    i0_op(32'h100, ld_ok(32'h0000_DEAD));
    i0_op(32'h102, ld_ok(32'h0000_BEEF));
    idle_all();
    drain();

    // Byte and word stores into a known word
    d0_op(1'b1, 2'b10, 32'h000, 32'h01020304, st_ok());
    d0_op(1'b1, 2'b00, 32'h003, 32'h0000_00A7, st_ok());
    d0_op(1'b1, 2'b01, 32'h000, 32'hFFFF_5A5B, st_ok());
    d0_op(1'b0, 2'b10, 32'h000, 32'h0, ld_ok(32'h5A5B_03A7));
    idle_all();
    drain();

    // Random words, then four back-to-back loads with req held high
    for (int k = 0; k < 4; k++) begin
      words[k] = $urandom;
      d0_op(1'b1, 2'b10, 32'h300 + 32'(4 * k), words[k], st_ok());
    end
    idle_all();
    drain();
    d0_op(1'b0, 2'b10, 32'h300, 32'h0, ld_ok(words[0]));
    #1 check("b2b_valid0", 64'(bus0.d_valid), 64'd1);
    d0_op(1'b0, 2'b00, 32'h305, 32'h0, ld_ok(ref_byte(words[1], 2'd1)));
    #1 check("b2b_valid1", 64'(bus0.d_valid), 64'd1);
    d0_op(1'b0, 2'b01, 32'h30A, 32'h0, ld_ok(ref_half(words[2], 1'b1)));
    #1 check("b2b_valid2", 64'(bus0.d_valid), 64'd1);
    d0_op(1'b0, 2'b00, 32'h30F, 32'h0, ld_ok(ref_byte(words[3], 2'd3)));
    #1 check("b2b_valid3", 64'(bus0.d_valid), 64'd1);
    idle_all();
    drain();

    // Rejected accesses: zero data, array untouched
    d0_op(1'b0, 2'b10, 32'h102, 32'h0, ld_err());
    d0_op(1'b0, 2'b01, 32'h001, 32'h0, ld_err());
    d0_op(1'b0, 2'b11, 32'h100, 32'h0, ld_err());
    d0_op(1'b0, 2'b10, 32'h4000, 32'h0, ld_err());
    d0_op(1'b1, 2'b10, 32'h102, 32'hFFFF_FFFF, st_err());
    d0_op(1'b1, 2'b11, 32'h100, 32'hFFFF_FFFF, st_err());
    d0_op(1'b1, 2'b01, 32'h101, 32'hFFFF_FFFF, st_err());
    d0_op(1'b1, 2'b10, 32'h4000, 32'hFFFF_FFFF, st_err());
    d0_op(1'b0, 2'b10, 32'h100, 32'h0, ld_ok(32'hDEAD_BEEF));
    d0_op(1'b0, 2'b10, 32'h000, 32'h0, ld_ok(32'h5A5B_03A7));
    idle_all();
    i0_op(32'h4001, ld_err());
    i0_op(32'h4000, ld_err());
    i0_op(32'h101, ld_err());
    i0_op(32'h3FFE, ld_ok(32'h0000_0000) & {W{1'b0}});
    idle_all();
    drain();

    // Store and fetch of the same word at one edge: fetch sees old data
    d0_op(1'b1, 2'b10, 32'h200, 32'h11223344, st_ok());
    idle_all();
    drain();
    fork
      d0_op(1'b1, 2'b00, 32'h200, 32'h0000_0055, st_ok());
      i0_op(32'h200, ld_ok(32'h0000_1122));
    join
    idle_all();
    drain();
    i0_op(32'h200, ld_ok(32'h0000_5522));
    i0_op(32'h202, ld_ok(32'h0000_3344));
    idle_all();
    d0_op(1'b0, 2'b10, 32'h200, 32'h0, ld_ok(32'h5522_3344));
    idle_all();
    drain();

    // Three wait states: ready low for three cycles, valid in the fourth
    d3_op(1'b1, 2'b10, 32'h40, 32'hCAFEF00D, st_ok());
    idle_all();
    drain();
    d3_op(1'b0, 2'b10, 32'h40, 32'h0, ld_ok(32'hCAFE_F00D));
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      bus3.d_req = 1'b0;
      check("ws3_ready_wait", 64'(bus3.d_ready), 64'd0);
      check("ws3_valid_wait", 64'(bus3.d_valid), 64'd0);
    end
    @(negedge clk);
    check("ws3_valid_resp", 64'(bus3.d_valid), 64'd1);
    check("ws3_ready_resp", 64'(bus3.d_ready), 64'd1);
    @(negedge clk);
    check("ws3_valid_after", 64'(bus3.d_valid), 64'd0);
    drain();

    // Reset during the wait of an accepted store: the store persists
    d3_op(1'b1, 2'b10, 32'h44, 32'h0BADC0DE, st_ok());
    @(negedge clk);
    bus3.d_req = 1'b0;
    n_reset = 1'b0;
    exp_d3_q.delete();
    #1;
    check("rst_store_d3_valid", 64'(bus3.d_valid), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_store_hold_valid", 64'(bus3.d_valid), 64'd0);
    end
    n_reset = 1'b1;

    // Reset during the wait of a load: no response, all outputs back to reset values
    d3_op(1'b0, 2'b10, 32'h40, 32'h0, ld_ok(32'hCAFE_F00D));
    @(negedge clk);
    bus3.d_req = 1'b0;
    @(negedge clk);
    n_reset = 1'b0;
    exp_d3_q.delete();
    #1;
    check_reset_outputs("mid");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("mid_hold_valid", 64'(bus3.d_valid), 64'd0);
      check("mid_hold_err", 64'(bus3.d_err), 64'd0);
    end
    n_reset = 1'b1;
    d3_op(1'b0, 2'b10, 32'h40, 32'h0, ld_ok(32'hCAFE_F00D));
    d3_op(1'b0, 2'b10, 32'h44, 32'h0, ld_ok(32'h0BAD_C0DE));
    d3_op(1'b0, 2'b00, 32'h47, 32'h0, ld_ok(32'h0000_00DE));
    idle_all();
    drain();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/sh_mem_responder.md
# sh_mem_responder

Memory-side responder for the core's instruction and data memory ports. It holds one shared 32-bit-wide, big-endian storage array. It serves 16-bit instruction fetches on one port and byte/word/long loads and stores on the other. Each port runs an independent accept/wait/respond sequencer with a programmable number of wait states, which lets the core's stall paths be exercised.

## Interface
- DEPTH_WORDS, 4096: number of 32-bit words in the array; byte address range is 0 to 4*DEPTH_WORDS-1.
- WAIT_STATES, 0: extra cycles inserted between acceptance and response, legal range 0..15, identical for both ports.
- clk  in  1  clock; all state changes on the rising edge.
- n_reset  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request.
- i_addr  in  32  fetch byte address.
- i_ready  out  1  port can accept a request this cycle.
- i_valid  out  1  one-cycle response strobe.
- i_rdata  out  16  fetched halfword.
- i_err  out  1  qualifies i_valid; the fetch was rejected.
- d_req  in  1  data request.
- d_we  in  1  1 = store, 0 = load.
- d_size  in  2  00 byte, 01 word (16-bit), 10 long (32-bit), 11 reserved.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data, right-justified.
- d_ready  out  1  port can accept a request this cycle.
- d_valid  out  1  one-cycle response strobe.
- d_rdata  out  32  load data, zero-extended and right-justified.
- d_err  out  1  qualifies d_valid; the access was rejected.

## Operation
- Handshake: a request is accepted at a rising edge when req=1 and ready=1. Inputs are sampled only at that edge, and the requester may change them afterwards.
- Per-port FSM states: IDLE, WAIT, RESP.
  - IDLE: ready=1. On accept, go to WAIT if WAIT_STATES>0, otherwise go to RESP.
  - WAIT: ready=0. An internal counter loads WAIT_STATES-1 on accept and decrements each cycle. Go to RESP when it reaches 0.
  - RESP: valid=1 for exactly one cycle and ready=1. An accept in RESP goes to WAIT or RESP as it would from IDLE. With no accept, go to IDLE.
- Array access occurs at the accept edge.
  - A store writes the selected byte lanes at that edge.
  - A load or fetch captures the array word into a holding register, which drives rdata during RESP.
- Big-endian lane mapping:
  - addr[1:0]=0 selects bits 31:24.
  - addr[1:0]=3 selects bits 7:0.
  - Word at addr[1]=0 selects bits 31:16.
  - Fetch at addr[1]=0 selects bits 31:16; at addr[1]=1 selects bits 15:0.
- Store data: byte uses d_wdata[7:0] and word uses d_wdata[15:0], placed in the addressed lanes. Other lanes are unchanged.
- Errors: any of the following raises err with valid in RESP, returns rdata=0, and leaves the array unchanged.
  - d_size=11.
  - Word access with addr[0]=1.
  - Long access with addr[1:0]≠0.
  - Fetch with i_addr[0]=1.
  - addr[31:2] ≥ DEPTH_WORDS on either port.
- Simultaneous accepts to the same word: a data store and a fetch or load on the other port at the same edge return the old contents (read-before-write). The store still takes effect.
- The ports never block each other. The array contents are not initialised by reset.

## Timing
- Response latency: for a request accepted at the edge ending cycle c, valid is high in cycle c+1+WAIT_STATES.
- Throughput per port: one request every 1+WAIT_STATES cycles. With WAIT_STATES=0 the port sustains one request per cycle.
- Outputs are registered or decoded from FSM state only; there are no combinational paths from req/addr to any output.
- Reset values: i_ready=1, d_ready=1, i_valid=0, d_valid=0, i_err=0, d_err=0, i_rdata=0, d_rdata=0, FSMs in IDLE, counters 0.
- Reset asserted mid-transaction abandons the pending response with no valid and no err. A store already accepted at a previous edge remains in the array.
- rdata and err hold their last values outside RESP. Consumers must qualify them with valid.

## Test plan
- Long store 0xDEADBEEF to 0x100, then byte load at 0x101 → d_rdata=0x000000AD; word load at 0x102 → 0x0000BEEF; fetch at 0x100 → i_rdata=0xDEAD.
- WAIT_STATES=3, load accepted at edge ending cycle 10 → d_ready=0 in cycles 11-13, d_valid=1 only in cycle 14.
- WAIT_STATES=0, four back-to-back loads with d_req held high → four consecutive d_valid cycles, each carrying the data for its own address in order.
- Long load at 0x102, word load at 0x001, d_size=11, and fetch at 0x4001 → d_err=1 or i_err=1 with rdata=0, and the array is unchanged. Fetch at 4*DEPTH_WORDS → i_err=1.
- Byte store 0x55 to 0x200 and fetch of 0x200 accepted at the same edge → i_rdata shows the old halfword, and a later fetch shows 0x55 in bits 15:8.
- n_reset pulsed low during WAIT of a load → no d_valid, and all outputs at reset values. After release, a new load completes normally with correct data.
